// File: rtl/add_serial_pkg.sv
// Shared defaults and FSM state encoding for the serial-adder sequencer.
package add_serial_pkg;

  localparam int unsigned WIDTH_DEF   = 8;
  localparam int unsigned LATENCY_DEF = 10;
  localparam int unsigned DEPTH_DEF   = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_GAP  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/add_serial_fifo.sv
// Synchronous FIFO of packed {a,b} operand pairs with full/empty flags.
module add_serial_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot the simultaneous push lands in, so full does not block it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/add_serial_seq.sv
// Sequencer for the serial adder: buffers operand pairs, pulses the adder, times its latency
// and returns sums. Define ADD_SERIAL_SEQ_CHECK_EN to add the chk_err/chk_pulse sum checker.
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             busy
`ifdef ADD_SERIAL_SEQ_CHECK_EN
  ,
  output logic             chk_err,
  output logic             chk_pulse
`endif
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  seq_state_t         state;
  logic [CW-1:0]      wait_cnt;
  logic [2*WIDTH-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               capture;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;

  assign push     = op_valid && !fifo_full;
  assign pop      = (state == S_IDLE) && !fifo_empty;
  assign op_ready = !fifo_full;
  assign busy     = (state != S_IDLE) || !fifo_empty;
  assign {head_a, head_b} = fifo_rdata;

  // The final WAIT cycle is the one whose decrement reaches zero.
  assign capture = (state == S_WAIT) && (wait_cnt <= CW'(1));

  add_serial_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({op_a, op_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      add_en    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
    end else begin
      add_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            add_a  <= head_a;
            add_b  <= head_b;
            add_en <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          wait_cnt <= CW'(LATENCY - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (capture) begin
            res_sum   <= add_out;
            res_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_GAP;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ADD_SERIAL_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_sum;

  // Reference sum taken at pop, compared against the adder at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_sum   <= '0;
      chk_err   <= 1'b0;
      chk_pulse <= 1'b0;
    end else begin
      chk_pulse <= 1'b0;
      if (pop) exp_sum <= head_a + head_b;
      if (capture && (add_out != exp_sum)) begin
        chk_err   <= 1'b1;
        chk_pulse <= 1'b1;
      end
    end
  end
`endif

endmodule
